// File: rtl/movimentacao_servo_pkg.sv
// Shared position/state codes for the servo sweep blocks, plus the rule that picks
// the next position and direction of the back-and-forth sweep.
package movimentacao_servo_pkg;

  localparam logic [1:0] POS_OFF = 2'b00;
  localparam logic [1:0] POS_01  = 2'b01;
  localparam logic [1:0] POS_10  = 2'b10;
  localparam logic [1:0] POS_11  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ESPERA = 2'b01,
    ST_AVANCA = 2'b10
  } estado_t;

  // Returns {sentido_next, posicao_next}. The ends turn straight back to 10, so no position repeats.
  function automatic logic [2:0] proxima_posicao(input logic [1:0] pos, input logic asc);
    logic [2:0] r;
    r = {1'b1, POS_01};
    case (pos)
      POS_01:  r = {1'b1, POS_10};
      POS_10:  r = asc ? {1'b1, POS_11} : {1'b0, POS_01};
      POS_11:  r = {1'b0, POS_10};
      default: r = {1'b1, POS_01};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/movimentacao_servo_contador_m.sv
// Modulo-M dwell counter: clears on zera, advances on conta, flags the last count.
module contador_m #(
  parameter int M = 50_000_000,
  parameter int N = 26
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q,
  output logic         fim
);

  localparam logic [N-1:0] Q_ULTIMO = N'(M - 1);

  logic [N-1:0] q_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else if (zera) begin
      q_reg <= '0;
    end else if (conta) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q   = q_reg;
  assign fim = (q_reg == Q_ULTIMO);

endmodule

// File: rtl/movimentacao_servo.sv
// Sweep sequencer for controle_servo: holds each position for M_ESPERA+1 cycles and
// steps 01 -> 10 -> 11 -> 10 -> 01 ..., pulsing fim_posicao on the cycle before each move.
module movimentacao_servo
  import movimentacao_servo_pkg::*;
#(
  parameter int M_ESPERA = 50_000_000,
  parameter int N_BITS   = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pausa,
  output logic [1:0] posicao,
  output logic       fim_posicao,
  output logic       sentido,
  output logic [1:0] db_estado
);

  estado_t           estado_reg;
  logic [1:0]        posicao_reg;
  logic              sentido_reg;
  logic              zera;
  logic              conta;
  logic              fim_contagem;
  logic [N_BITS-1:0] contagem;

  contador_m #(
    .M (M_ESPERA),
    .N (N_BITS)
  ) u_contador (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta),
    .q     (contagem),
    .fim   (fim_contagem)
  );

  // The counter only runs while dwelling and enabled; pausa freezes it, every other case clears it.
  always_comb begin
    zera  = 1'b1;
    conta = 1'b0;
    if (estado_reg == ST_ESPERA && ligar) begin
      if (pausa) begin
        zera = 1'b0;
      end else if (!fim_contagem) begin
        zera  = 1'b0;
        conta = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg  <= ST_IDLE;
      posicao_reg <= POS_OFF;
      sentido_reg <= 1'b1;
    end else begin
      case (estado_reg)
        ST_IDLE: begin
          if (ligar) begin
            estado_reg  <= ST_ESPERA;
            posicao_reg <= POS_01;
            sentido_reg <= 1'b1;
          end
        end
        ST_ESPERA: begin
          if (!ligar) begin
            estado_reg  <= ST_IDLE;
            posicao_reg <= POS_OFF;
            sentido_reg <= 1'b1;
          end else if (!pausa && fim_contagem) begin
            estado_reg <= ST_AVANCA;
          end
        end
        ST_AVANCA: begin
          // Disabling wins over the move that would otherwise happen here.
          if (!ligar) begin
            estado_reg  <= ST_IDLE;
            posicao_reg <= POS_OFF;
            sentido_reg <= 1'b1;
          end else begin
            {sentido_reg, posicao_reg} <= proxima_posicao(posicao_reg, sentido_reg);
            estado_reg                 <= ST_ESPERA;
          end
        end
        default: begin
          estado_reg  <= ST_IDLE;
          posicao_reg <= POS_OFF;
          sentido_reg <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (contagem <= N_BITS'(M_ESPERA - 1));
    end
  end

  assign posicao     = posicao_reg;
  assign sentido     = sentido_reg;
  assign db_estado   = estado_reg;
  assign fim_posicao = (estado_reg == ST_AVANCA);

endmodule

// File: tb/tb_movimentacao_servo.sv
// Directed bench for movimentacao_servo with a 4-cycle dwell (5 cycles per position).
module tb_movimentacao_servo;

  logic       clock;
  logic       reset;
  logic       ligar;
  logic       pausa;
  logic [1:0] posicao;
  logic       fim_posicao;
  logic       sentido;
  logic [1:0] db_estado;

  int total = 0;
  int bad   = 0;

  movimentacao_servo #(
    .M_ESPERA (4),
    .N_BITS   (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ligar       (ligar),
    .pausa       (pausa),
    .posicao     (posicao),
    .fim_posicao (fim_posicao),
    .sentido     (sentido),
    .db_estado   (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Hand-derived sweep for positions 0..6 after enable, with the direction held during each.
  logic [1:0] pos_tab [7] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10, 2'b11};
  logic       sen_tab [7] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};

  initial begin
    int pulses;
    int last_pulse;
    int idx;
    reset = 1'b0;
    ligar = 1'b0;
    pausa = 1'b0;
    pulses = 0;
    last_pulse = 0;
    repeat (2) @(negedge clock);

    check("rst_posicao", 32'(posicao), 32'h0);
    check("rst_sentido", 32'(sentido), 32'h1);
    check("rst_fim", 32'(fim_posicao), 32'h0);
    check("rst_estado", 32'(db_estado), 32'h0);

    reset = 1'b1;
    @(negedge clock);
    check("idle_no_ligar", 32'(posicao), 32'h0);

    // T1/T2: enable, then follow the sweep for 30 cycles.
    ligar = 1'b1;
    check("t1_pre_edge", 32'(posicao), 32'h0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      idx = (k - 1) / 5;
      check($sformatf("c%0d_posicao", k), 32'(posicao), 32'(pos_tab[idx]));
      check($sformatf("c%0d_sentido", k), 32'(sentido), 32'(sen_tab[idx]));
      check($sformatf("c%0d_fim", k), 32'(fim_posicao), ((k - 1) % 5 == 4) ? 32'h1 : 32'h0);
      if (fim_posicao) begin
        if (last_pulse != 0) check($sformatf("c%0d_pulse_gap", k), 32'(k - last_pulse), 32'd5);
        last_pulse = k;
        pulses++;
      end
    end
    check("t2_pulse_count", 32'(pulses), 32'd6);

    @(negedge clock);  // cycle 31
    check("c31_posicao", 32'(posicao), 32'h3);
    check("c31_sentido", 32'(sentido), 32'h1);

    // T3: freeze for 7 edges in mid-dwell.
    @(negedge clock);  // cycle 32
    pausa = 1'b1;
    for (int k = 33; k <= 39; k++) begin
      @(negedge clock);
      check($sformatf("c%0d_pausa_posicao", k), 32'(posicao), 32'h3);
      check($sformatf("c%0d_pausa_fim", k), 32'(fim_posicao), 32'h0);
      check($sformatf("c%0d_pausa_estado", k), 32'(db_estado), 32'h1);
    end
    pausa = 1'b0;
    @(negedge clock);
    check("c40_fim", 32'(fim_posicao), 32'h0);
    @(negedge clock);
    check("c41_fim", 32'(fim_posicao), 32'h0);
    @(negedge clock);
    check("c42_fim", 32'(fim_posicao), 32'h1);
    @(negedge clock);
    check("c43_posicao", 32'(posicao), 32'h2);
    check("c43_sentido", 32'(sentido), 32'h0);

    // T4: drop ligar during the pulse cycle.
    repeat (4) @(negedge clock);  // cycle 47
    check("c47_fim", 32'(fim_posicao), 32'h1);
    ligar = 1'b0;
    @(negedge clock);
    check("c48_posicao", 32'(posicao), 32'h0);
    check("c48_estado", 32'(db_estado), 32'h0);
    check("c48_fim", 32'(fim_posicao), 32'h0);
    check("c48_sentido", 32'(sentido), 32'h1);
    ligar = 1'b1;
    @(negedge clock);
    check("c49_posicao", 32'(posicao), 32'h1);
    check("c49_sentido", 32'(sentido), 32'h1);
    check("c49_estado", 32'(db_estado), 32'h1);

    // T5: asynchronous reset between edges while at 11.
    repeat (11) @(negedge clock);  // cycle 60
    check("c60_posicao", 32'(posicao), 32'h3);
    #2 reset = 1'b0;
    #1;
    check("async_posicao", 32'(posicao), 32'h0);
    check("async_sentido", 32'(sentido), 32'h1);
    check("async_fim", 32'(fim_posicao), 32'h0);
    check("async_estado", 32'(db_estado), 32'h0);
    ligar = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_idle", 32'(posicao), 32'h0);
    ligar = 1'b1;
    @(negedge clock);
    check("restart_posicao", 32'(posicao), 32'h1);
    check("restart_sentido", 32'(sentido), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
